time_alarm_set_display: RTL and testbench

Front-end block for the digital clock/alarm: holds the user-editable current-time (MM:SS) and alarm-time registers, edited digit by digit with four push buttons under two mode switches. It also contains the hex-to-7-segment decoder with alarm blink that drives the display cathodes. It sits between the board I/O (switches, buttons, 7-segment) and the time-keeping, stopwatch and alarm services.

---
 rtl/time_alarm_set_display_if.sv | 28 ++
 rtl/time_alarm_set_display.sv | 156 +++++++++++++++
 tb/tb_time_alarm_set_display.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/time_alarm_set_display_if.sv
// Board-side signal bundle for the time/alarm set-and-display front end.
// master = switch/button/number source, slave = the set/display block.
interface time_alarm_set_display_if;
    logic        spdt1;
    logic        spdt2;
    logic        push_u;
    logic        push_d;
    logic        push_l;
    logic        push_r;
    logic [3:0]  number;
    logic        alarm_on;
    logic [15:0] time_num;
    logic [3:0]  time_sel;
    logic        finish1;
    logic [15:0] alarm_num;
    logic [3:0]  alarm_sel;
    logic [6:0]  seg;

    modport master (
        output spdt1, spdt2, push_u, push_d, push_l, push_r, number, alarm_on,
        input  time_num, time_sel, finish1, alarm_num, alarm_sel, seg
    );

    modport slave (
        input  spdt1, spdt2, push_u, push_d, push_l, push_r, number, alarm_on,
        output time_num, time_sel, finish1, alarm_num, alarm_sel, seg
    );
endinterface

// File: rtl/time_alarm_set_display.sv
// Digit-by-digit MM:SS editors for current time and alarm time, plus the
// hex-to-7-segment decoder with alarm blink.
module time_alarm_set_display #(
    parameter int unsigned BLINK_BIT = 10
) (
    input  logic                      clk_osc,
    input  logic                      RESET,
    time_alarm_set_display_if.slave   bus
);

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    // bit order: {spdt1, spdt2, push_u, push_d, push_l, push_r}
    logic [5:0]  raw_in;
    logic [5:0]  sync1;
    logic [5:0]  sync2;
    logic [5:0]  hist;
    logic [5:0]  rise;
    logic [5:0]  fall;
    action_t     act;

    logic [15:0] time_num;
    logic [3:0]  time_sel;
    logic        finish1;
    logic [15:0] alarm_num;
    logic [3:0]  alarm_sel;
    logic [12:0] blink_cnt;
    logic [6:0]  decoded;

    assign raw_in = {bus.spdt1, bus.spdt2, bus.push_u, bus.push_d, bus.push_l, bus.push_r};
    assign rise   = sync2 & ~hist;
    assign fall   = ~sync2 & hist;

    always_ff @(posedge clk_osc) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_comb begin
        act = ACT_NONE;
        if (rise[3])      act = ACT_UP;
        else if (rise[2]) act = ACT_DOWN;
        else if (rise[1]) act = ACT_LEFT;
        else if (rise[0]) act = ACT_RIGHT;
    end

    // Minute/second tens digits run 0-5, ones digits 0-9; no carry between digits.
    function automatic logic [15:0] edit_digits(logic [15:0] num, logic [3:0] sel, action_t a);
        logic [15:0] r;
        logic [3:0]  d;
        logic [3:0]  mx;
        r = num;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) begin
                d  = num[i*4 +: 4];
                mx = (i % 2 == 1) ? 4'd5 : 4'd9;
                if (a == ACT_UP)
                    r[i*4 +: 4] = (d >= mx) ? 4'd0 : d + 4'd1;
                else if (a == ACT_DOWN)
                    r[i*4 +: 4] = (d == 4'd0) ? mx : d - 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] next_sel(logic [3:0] sel, action_t a);
        case (a)
            ACT_LEFT:  return {sel[2:0], sel[3]};
            ACT_RIGHT: return {sel[0], sel[3:1]};
            default:   return sel;
        endcase
    endfunction

    // Entry/exit edges take precedence over a button edge in the same cycle.
    always_ff @(posedge clk_osc) begin
        if (RESET) begin
            time_num <= '0;
            time_sel <= '0;
            finish1  <= 1'b0;
        end else begin
            finish1 <= fall[5];
            if (rise[5]) begin
                time_sel <= 4'b0100;
            end else if (fall[5]) begin
                time_sel <= '0;
            end else if (sync2[5]) begin
                time_num <= edit_digits(time_num, time_sel, act);
                time_sel <= next_sel(time_sel, act);
            end
        end
    end

    // The time editor owns the buttons whenever both mode switches are high.
    always_ff @(posedge clk_osc) begin
        if (RESET) begin
            alarm_num <= '0;
            alarm_sel <= '0;
        end else begin
            if (rise[4]) begin
                alarm_sel <= 4'b0100;
            end else if (fall[4]) begin
                alarm_sel <= '0;
            end else if (sync2[4] && !sync2[5]) begin
                alarm_num <= edit_digits(alarm_num, alarm_sel, act);
                alarm_sel <= next_sel(alarm_sel, act);
            end
        end
    end

    always_ff @(posedge clk_osc) begin
        if (RESET) blink_cnt <= '0;
        else       blink_cnt <= blink_cnt + 13'd1;
    end

    always_comb begin
        case (bus.number)
            4'h0:    decoded = 7'b0000001;
            4'h1:    decoded = 7'b1001111;
            4'h2:    decoded = 7'b0010010;
            4'h3:    decoded = 7'b0000110;
            4'h4:    decoded = 7'b1001100;
            4'h5:    decoded = 7'b0100100;
            4'h6:    decoded = 7'b0100000;
            4'h7:    decoded = 7'b0001111;
            4'h8:    decoded = 7'b0000000;
            4'h9:    decoded = 7'b0000100;
            4'hA:    decoded = 7'b0001000;
            4'hB:    decoded = 7'b1100000;
            4'hC:    decoded = 7'b0110001;
            4'hD:    decoded = 7'b1000010;
            4'hE:    decoded = 7'b0110000;
            default: decoded = 7'b0111000;
        endcase
    end

    assign bus.seg       = (bus.alarm_on && blink_cnt[BLINK_BIT]) ? '1 : decoded;
    assign bus.time_num  = time_num;
    assign bus.time_sel  = time_sel;
    assign bus.finish1   = finish1;
    assign bus.alarm_num = alarm_num;
    assign bus.alarm_sel = alarm_sel;

endmodule

// File: tb/tb_time_alarm_set_display.sv
// Bench for time_alarm_set_display: directed plan steps, then random button and
// switch activity compared against a digit-array model, then decoder/blink.
module tb_time_alarm_set_display;

    localparam int unsigned BB = 10;

    logic clk_osc = 1'b0;
    logic RESET   = 1'b1;

    time_alarm_set_display_if bus();

    time_alarm_set_display #(.BLINK_BIT(BB)) dut (
        .clk_osc (clk_osc),
        .RESET   (RESET),
        .bus     (bus)
    );

    always #10 clk_osc = ~clk_osc;

    int checks   = 0;
    int failures = 0;

    // cycles since reset release, and finish1 pulses seen
    int unsigned cyc = 0;
    int fin_seen = 0;
    always @(posedge clk_osc) cyc <= RESET ? 0 : cyc + 1;
    always @(negedge clk_osc) if (bus.finish1 === 1'b1) fin_seen++;

    // Reference model: editor 0 = time, editor 1 = alarm; digit index 3 = M tens
    int dig [2][4];
    int pos [2];
    bit ed  [2];
    bit sw  [2];
    int exp_fin = 0;

    logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [15:0] num_of(int e);
        return {4'(dig[e][3]), 4'(dig[e][2]), 4'(dig[e][1]), 4'(dig[e][0])};
    endfunction

    function automatic logic [3:0] sel_of(int e);
        return ed[e] ? 4'(1 << pos[e]) : 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_osc);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_time_num"},  bus.time_num,  num_of(0));
        chk({tag, "_time_sel"},  bus.time_sel,  sel_of(0));
        chk({tag, "_alarm_num"}, bus.alarm_num, num_of(1));
        chk({tag, "_alarm_sel"}, bus.alarm_sel, sel_of(1));
        chk({tag, "_finish1"},   16'(bus.finish1), 16'd0);
    endtask

    // mask bit0=up, bit1=down, bit2=left, bit3=right
    task automatic model_press(input logic [3:0] mask);
        int e;
        int p;
        int mx;
        e = sw[0] ? 0 : (sw[1] ? 1 : -1);
        if (e < 0 || mask == 4'b0000) return;
        p  = pos[e];
        mx = (p % 2 == 1) ? 5 : 9;
        if (mask[0])      dig[e][p] = (dig[e][p] == mx) ? 0 : dig[e][p] + 1;
        else if (mask[1]) dig[e][p] = (dig[e][p] == 0) ? mx : dig[e][p] - 1;
        else if (mask[2]) pos[e] = (p + 1) % 4;
        else              pos[e] = (p + 3) % 4;
    endtask

    task automatic press_mask(input logic [3:0] mask, input int hold);
        bus.push_u = mask[0];
        bus.push_d = mask[1];
        bus.push_l = mask[2];
        bus.push_r = mask[3];
        tick(hold);
        bus.push_u = 1'b0;
        bus.push_d = 1'b0;
        bus.push_l = 1'b0;
        bus.push_r = 1'b0;
        model_press(mask);
        tick(3);
        check_state("press");
    endtask

    task automatic set_sw(input int w, input bit v);
        logic [3:0] old_sel;
        bit falling;
        old_sel = sel_of(w);
        falling = sw[w] && !v;
        if (sw[w] == v) return;
        if (w == 0) bus.spdt1 = v;
        else        bus.spdt2 = v;
        sw[w] = v;
        if (v) begin
            ed[w]  = 1'b1;
            pos[w] = 2;
        end else begin
            ed[w] = 1'b0;
        end
        tick(2);
        chk("sw_latency_sel", w == 0 ? bus.time_sel : bus.alarm_sel, old_sel);
        tick(1);
        chk("sw_sel", w == 0 ? bus.time_sel : bus.alarm_sel, sel_of(w));
        if (w == 0 && falling) begin
            exp_fin++;
            chk("finish1_pulse", 16'(bus.finish1), 16'd1);
            tick(1);
            check_state("after_finish");
        end else begin
            chk("sw_finish1_idle", 16'(bus.finish1), 16'd0);
        end
    endtask

    initial begin
        logic [3:0] m;
        int n;
        int r;
        bus.spdt1 = 1'b0;  bus.spdt2 = 1'b0;
        bus.push_u = 1'b0; bus.push_d = 1'b0;
        bus.push_l = 1'b0; bus.push_r = 1'b0;
        bus.number = 4'd0; bus.alarm_on = 1'b0;
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 4; i++) dig[e][i] = 0;
            pos[e] = 2; ed[e] = 1'b0; sw[e] = 1'b0;
        end

        // reset
        RESET = 1'b1;
        tick(2);
        check_state("reset");
        RESET = 1'b0;
        tick(1);
        check_state("post_reset");

        // time edit plan
        set_sw(0, 1'b1);
        press_mask(4'b0001, 2);
        chk("plan_up", bus.time_num, 16'h0100);
        press_mask(4'b0100, 2);
        press_mask(4'b0100, 2);
        chk("plan_sel_sones", bus.time_sel, 16'h0001);
        press_mask(4'b0010, 2);
        chk("plan_down_wrap", bus.time_num, 16'h0109);
        set_sw(0, 1'b0);
        chk("plan_held", bus.time_num, 16'h0109);

        // M tens wrap through 1..5,0
        set_sw(0, 1'b1);
        press_mask(4'b0100, 1);
        for (int i = 0; i < 6; i++) press_mask(4'b0001, 3);
        chk("mtens_wrap", bus.time_num, 16'h0109);
        press_mask(4'b1000, 1);
        press_mask(4'b1000, 1);
        press_mask(4'b0010, 1);
        chk("sten_down_wrap", bus.time_num, 16'h0159);
        set_sw(0, 1'b0);

        // alarm edit, then both switches high
        set_sw(1, 1'b1);
        press_mask(4'b0001, 2);
        chk("alarm_up", bus.alarm_num, 16'h0100);
        set_sw(0, 1'b1);
        press_mask(4'b0001, 2);
        chk("both_time", bus.time_num, 16'h0259);
        chk("both_alarm", bus.alarm_num, 16'h0100);
        set_sw(0, 1'b0);
        set_sw(1, 1'b0);

        // held button and simultaneous edges
        set_sw(0, 1'b1);
        press_mask(4'b0001, 1000);
        chk("held_once", bus.time_num, 16'h0359);
        press_mask(4'b1111, 2);
        press_mask(4'b1100, 2);

        // randomized activity
        for (int k = 0; k < 160; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      set_sw(0, !sw[0]);
            else if (r == 1) set_sw(1, !sw[1]);
            else begin
                if ($urandom_range(0, 4) == 0) m = 4'($urandom_range(1, 15));
                else                           m = 4'(1 << $urandom_range(0, 3));
                press_mask(m, int'($urandom_range(1, 6)));
            end
        end
        set_sw(0, 1'b0);
        set_sw(1, 1'b0);
        tick(2);
        chk("finish1_count", 16'(fin_seen), 16'(exp_fin));

        // decoder sweep without blink
        for (int i = 0; i < 16; i++) begin
            bus.number = 4'(i);
            #1;
            chk("decode", 16'(bus.seg), 16'(seg_tbl[i]));
            tick(1);
        end

        // blink phase tracks cycles since reset
        bus.alarm_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            n = int'($urandom_range(0, 15));
            bus.number = 4'(n);
            tick(16);
            chk("blink", 16'(bus.seg),
                ((cyc % 8192) >> BB) % 2 == 1 ? 16'h007F : 16'(seg_tbl[n]));
        end
        bus.alarm_on = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 15));
            bus.number = 4'(n);
            tick(64);
            chk("no_blink", 16'(bus.seg), 16'(seg_tbl[n]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
